// File: rtl/rsa_operand_stage.sv
// Word-wide operand load / result unload front end for the modular exponentiator.
// Operands are assembled from host words, one job is launched, and c is served back by word.
module rsa_operand_stage #(
  parameter int W  = 2048,
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          go,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   cycles,
  output logic          exp_start,
  input  logic          exp_ready,
  output logic [W-1:0]  exp_m,
  output logic [W-1:0]  exp_e,
  output logic [W-1:0]  exp_n,
  input  logic [W-1:0]  exp_c
);
  localparam int NW = 1 << AW;

  typedef enum logic [2:0] {IDLE, LAUNCH, ACK, RUN, DONE} state_t;
  state_t state, state_d;

  logic [NW-1:0][DW-1:0] m_q, e_q, n_q, res_q;

  assign exp_m = m_q;
  assign exp_e = e_q;
  assign exp_n = n_q;
  assign busy  = (state == LAUNCH) || (state == ACK) || (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (go) state_d = LAUNCH;
      LAUNCH:     state_d = ACK;
      // wait for the exponentiator to drop ready so a stale ready is not taken as completion
      ACK:        if (!exp_ready) state_d = RUN;
      RUN:        if (exp_ready) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      e_q       <= '0;
      n_q       <= '0;
      res_q     <= '0;
      rd_data   <= '0;
      cycles    <= '0;
      exp_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      exp_start <= (state_d == LAUNCH);

      // writes land on the same edge as go, so a launched job sees them
      if (wr_en) begin
        if (busy) err <= 1'b1;
        else begin
          case (wr_sel)
            2'd0:    m_q[wr_addr] <= wr_data;
            2'd1:    e_q[wr_addr] <= wr_data;
            2'd2:    n_q[wr_addr] <= wr_data;
            default: ;
          endcase
        end
      end

      if (go && busy) err <= 1'b1;

      if (go && !busy) begin
        done   <= 1'b0;
        cycles <= '0;
      end else if ((state == ACK || state == RUN) && cycles != 32'hFFFF_FFFF) begin
        cycles <= cycles + 32'd1;
      end

      if (state == RUN && exp_ready) begin
        res_q <= exp_c;
        done  <= 1'b1;
      end

      if (rd_en) rd_data <= res_q[rd_addr];
    end
  end
endmodule

// File: tb/tb_rsa_operand_stage.sv
// Directed bench for rsa_operand_stage with a small behavioural exponentiator (low-word modexp).
module tb_rsa_operand_stage;
  localparam int W = 2048, DW = 32, AW = 6;

  logic          clk = 0;
  logic          rst = 1;
  logic          wr_en = 0;
  logic [1:0]    wr_sel = 0;
  logic [AW-1:0] wr_addr = 0;
  logic [DW-1:0] wr_data = 0;
  logic          go = 0;
  logic          rd_en = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [DW-1:0] rd_data;
  logic          busy, done, err, exp_start;
  logic [31:0]   cycles;
  logic          exp_ready;
  logic [W-1:0]  exp_m, exp_e, exp_n, exp_c;

  int checks = 0, passes = 0, starts = 0, base = 0, lat = 0, cnt = 0;

  rsa_operand_stage #(.W(W), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .go(go), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .cycles(cycles), .exp_start(exp_start),
    .exp_ready(exp_ready), .exp_m(exp_m), .exp_e(exp_e), .exp_n(exp_n), .exp_c(exp_c)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] n);
    longint unsigned r, x;
    if (n == 0) return 32'd0;
    r = 1 % longint'(n);
    x = longint'(b) % longint'(n);
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % longint'(n);
      x = (x * x) % longint'(n);
    end
    return r[31:0];
  endfunction

  // exponentiator model: ready drops after start, rises lat+1 cycles later with the result
  always @(posedge clk) begin
    if (exp_start) starts <= starts + 1;
    if (rst) begin
      exp_ready <= 1'b1;
      cnt       <= 0;
      exp_c     <= '0;
    end else if (exp_start) begin
      exp_ready <= 1'b0;
      cnt       <= lat;
    end else if (!exp_ready) begin
      if (cnt == 0) begin
        exp_ready  <= 1'b1;
        exp_c      <= '0;
        exp_c[31:0] <= modexp(exp_m[31:0], exp_e[31:0], exp_n[31:0]);
      end else cnt <= cnt - 1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1; wr_sel = sel; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1; rd_addr = a;
    step();
    rd_en = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin step(); n++; end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    // reset state
    step(); step();
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_cycles", 64'(cycles), 0);
    check("rst_start", 64'(exp_start), 0);
    check("rst_rd", 64'(rd_data), 0);
    rst = 0;
    step();

    // basic job: 2^10 mod 1000 = 24
    lat = 0;
    wr(2'd0, 0, 32'h2); wr(2'd1, 0, 32'hA); wr(2'd2, 0, 32'h3E8);
    base = starts;
    go = 1; step(); go = 0;
    check("go_start", 64'(exp_start), 1);
    check("go_busy", 64'(busy), 1);
    wait_done("basic_done");
    check("basic_starts", 64'(starts - base), 1);
    rd(0);  check("basic_w0", 64'(rd_data), 64'h18);
    rd(1);  check("basic_w1", 64'(rd_data), 0);
    rd(63); check("basic_w63", 64'(rd_data), 0);
    step(); check("rd_hold", 64'(rd_data), 0);

    // back-to-back: 3^10 mod 1000 = 49; old result readable until capture
    lat = 3;
    wr(2'd0, 0, 32'h3);
    go = 1; step(); go = 0;
    check("b2b_done_drop", 64'(done), 0);
    check("b2b_busy", 64'(busy), 1);
    rd(0); check("b2b_old_result", 64'(rd_data), 64'h18);
    wait_done("b2b_done");
    check("b2b_cycles", 64'(cycles), 5);
    rd(0); check("b2b_new_result", 64'(rd_data), 64'h31);

    // write and go while busy are dropped and flag err
    check("err_clear", 64'(err), 0);
    lat = 5;
    base = starts;
    go = 1; step(); go = 0;
    step(); step();
    wr(2'd0, 0, 32'h5);
    check("busy_wr_err", 64'(err), 1);
    check("busy_wr_dropped", 64'(exp_m[31:0]), 64'h3);
    go = 1; step(); go = 0;
    wait_done("busy_done");
    check("busy_one_start", 64'(starts - base), 1);
    rd(0); check("busy_result", 64'(rd_data), 64'h31);
    check("err_sticky", 64'(err), 1);

    // write and go in the same idle cycle: 3^3 mod 1000 = 27
    lat = 0;
    wr_en = 1; wr_sel = 2'd1; wr_addr = 0; wr_data = 32'h3; go = 1;
    step();
    wr_en = 0; go = 0;
    check("same_start", 64'(exp_start), 1);
    check("same_e", 64'(exp_e[31:0]), 64'h3);
    wait_done("same_done");
    rd(0); check("same_result", 64'(rd_data), 64'h1B);

    // wr_sel=3 is a no-op
    wr(2'd3, 0, 32'hDEAD);
    check("sel3_m", 64'(exp_m[31:0]), 64'h3);
    check("sel3_e", 64'(exp_e[31:0]), 64'h3);
    check("sel3_n", 64'(exp_n[31:0]), 64'h3E8);

    // exact launch timing with m = 0
    wr(2'd0, 0, 32'h0);
    go = 1; step(); go = 0;
    check("t1_start", 64'(exp_start), 1);
    step();
    check("t2_start", 64'(exp_start), 0);
    check("t2_busy", 64'(busy), 1);
    step();
    check("t3_busy", 64'(busy), 1);
    check("t3_done", 64'(done), 0);
    step();
    check("t4_done", 64'(done), 1);
    check("t4_busy", 64'(busy), 0);
    check("t4_cycles", 64'(cycles), 2);
    rd(0); check("t4_result", 64'(rd_data), 0);

    // reset mid-run, then clean restart
    lat = 5;
    go = 1; step(); go = 0;
    step(); step();
    rst = 1; step(); rst = 0;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_done", 64'(done), 0);
    check("mid_rst_err", 64'(err), 0);
    check("mid_rst_cycles", 64'(cycles), 0);
    check("mid_rst_start", 64'(exp_start), 0);
    check("mid_rst_rd", 64'(rd_data), 0);
    check("mid_rst_m", 64'(exp_m[31:0]), 0);
    check("mid_rst_n", 64'(exp_n[31:0]), 0);
    lat = 0;
    wr(2'd0, 0, 32'h2); wr(2'd1, 0, 32'hA); wr(2'd2, 0, 32'h3E8);
    base = starts;
    go = 1; step(); go = 0;
    wait_done("restart_done");
    check("restart_cycles", 64'(cycles), 2);
    check("restart_starts", 64'(starts - base), 1);
    rd(0); check("restart_result", 64'(rd_data), 64'h18);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rsa_operand_stage.md
RSA_OPERAND_STAGE -- requirements
Module: rsa_operand_stage

Word-wide load/unload front end for the modular exponentiator: assembles W-bit operands m, e and n from DW-bit writes, launches one exponentiation, captures c, and serves it back word by word.

Interface
REQ-001 SHALL have parameter W, default 2048: operand/result width in bits.
REQ-002 SHALL have parameter DW, default 32: host word width in bits.
REQ-003 SHALL have parameter AW, default 6: word-address width; W SHALL equal DW*2^AW.
REQ-004 SHALL have port clk, input, 1: sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1: operand word write strobe.
REQ-007 SHALL have port wr_sel, input, 2: write target (0 = m, 1 = e, 2 = n, 3 = none).
REQ-008 SHALL have port wr_addr, input, AW: word index; word k = bits [DW*k+DW-1 : DW*k].
REQ-009 SHALL have port wr_data, input, DW: write word.
REQ-010 SHALL have port go, input, 1: launch request.
REQ-011 SHALL have port rd_en, input, 1: result read strobe.
REQ-012 SHALL have port rd_addr, input, AW: result word index.
REQ-013 SHALL have port rd_data, output, DW: registered result word.
REQ-014 SHALL have port busy, output, 1: high while a job is in flight.
REQ-015 SHALL have port done, output, 1: sticky result-valid flag.
REQ-016 SHALL have port err, output, 1: sticky protocol-violation flag.
REQ-017 SHALL have port cycles, output, 32: exponentiation duration counter.
REQ-018 SHALL have port exp_start, output, 1: start pulse to the exponentiator.
REQ-019 SHALL have port exp_ready, input, 1: exponentiator idle/ready.
REQ-020 SHALL have ports exp_m, exp_e, exp_n, output, W each: operand registers, driven directly.
REQ-021 SHALL have port exp_c, input, W: exponentiator result.

Function
REQ-022 SHALL implement states IDLE, LAUNCH, ACK, RUN, DONE; busy = state in {LAUNCH, ACK, RUN}.
REQ-023 IDLE/DONE: go=1 -> LAUNCH; also clears done, clears cycles to 0.
REQ-024 LAUNCH: exp_start = 1 for exactly this one cycle (registered) -> ACK unconditionally.
REQ-025 ACK: exp_ready = 0 -> RUN; otherwise stay in ACK.
REQ-026 RUN: exp_ready = 1 -> capture exp_c into result register, set done, -> DONE.
REQ-027 cycles SHALL increment once per cycle spent in ACK or RUN; saturates at 0xFFFFFFFF; holds in IDLE/DONE.
REQ-028 Writes accepted only when busy = 0: target word updated at the clock edge; wr_sel = 3 is a no-op.
REQ-029 wr_en=1 while busy=1 SHALL be dropped and set err; go=1 while busy=1 SHALL be ignored and set err.
REQ-030 wr_en and go in the same IDLE cycle: the write SHALL land before exp_start, so the launched job uses the new word.
REQ-031 rd_en=1: rd_data <= result word rd_addr, 1-cycle latency; rd_en=0 holds rd_data; reads are legal in any state.
REQ-032 Result register SHALL change only on the RUN capture; operand registers persist across jobs.
REQ-033 err SHALL clear only on rst.

Reset
REQ-034 rst=1 SHALL force IDLE; exp_m, exp_e, exp_n, result, rd_data, cycles = 0; exp_start, busy, done, err = 0.
REQ-035 rst SHALL take precedence over all inputs, including mid-job (any state -> IDLE, no capture); the exponentiator shares rst.

Verification
REQ-036 Write m.w0=0x2, e.w0=0xA, n.w0=0x3E8, all other words 0; go -> one exp_start pulse, done=1, read w0 = 0x18, w1..w63 = 0.
REQ-037 m all zero; go in cycle t -> exp_start high in t+1, ACK t+2, RUN t+3, done=1 in t+4; cycles=2; result = 0.
REQ-038 Write m.w0=0x5 during RUN -> exp_m unchanged, err=1, job completes normally; a second go during RUN -> ignored, still one exp_start.
REQ-039 wr_en (e.w0=0x3) and go in the same IDLE cycle -> exp_e[31:0]=0x3 at the exp_start cycle.
REQ-040 rst asserted in RUN -> next cycle IDLE, all outputs 0; a later go restarts cleanly with cycles counted from 0.
REQ-041 Back-to-back: go in DONE -> done drops next cycle; the new result overwrites the old one only at the new capture.
